// File: rtl/vectored_interrupt_controller_if.sv
// Register/request bundle for vectored_interrupt_controller.
//   interrupts  : async request lines (bit0 = int1)
//   intDisabled : CPU in handler, doubles as acknowledge
//   cfg_we/cfg_addr/cfg_wdata : register write port (0 ENABLE, 1 MODE, 2 PENDING, 3 SOFT_TRIG)
//   cfg_rdata   : registered read data for cfg_addr
//   intCPU/intID: request to CPU and 1-based ID of the dispatched line
// master = CPU/software side, slave = controller side.
interface vectored_interrupt_controller_if #(
    parameter int unsigned NUM_INTERRUPTS = 16
);
    logic [NUM_INTERRUPTS-1:0] interrupts;
    logic                      intDisabled;
    logic                      cfg_we;
    logic [1:0]                cfg_addr;
    logic [NUM_INTERRUPTS-1:0] cfg_wdata;
    logic [NUM_INTERRUPTS-1:0] cfg_rdata;
    logic                      intCPU;
    logic [7:0]                intID;

    modport master (
        output interrupts, intDisabled, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rdata, intCPU, intID
    );

    modport slave (
        input  interrupts, intDisabled, cfg_we, cfg_addr, cfg_wdata,
        output cfg_rdata, intCPU, intID
    );
endinterface

// File: rtl/vectored_interrupt_controller.sv
// Vectored interrupt controller.
// Synchronises NUM_INTERRUPTS lines, latches them (edge or level per MODE) into PENDING,
// masks with ENABLE and dispatches the lowest-indexed enabled pending line as intCPU + intID.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : vectored_interrupt_controller_if.slave (lines, acknowledge, register port, request)
module vectored_interrupt_controller #(
    parameter int unsigned NUM_INTERRUPTS = 16,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input logic                                 clk,
    input logic                                 reset,
    vectored_interrupt_controller_if.slave      bus
);

    localparam logic [1:0] AddrEnable   = 2'd0;
    localparam logic [1:0] AddrMode     = 2'd1;
    localparam logic [1:0] AddrPending  = 2'd2;
    localparam logic [1:0] AddrSoftTrig = 2'd3;

    typedef logic [NUM_INTERRUPTS-1:0] vec_t;

    vec_t       sync_q [SYNC_STAGES];
    vec_t       sync_prev_q;
    vec_t       enable_q, enable_d;
    vec_t       mode_q, mode_d;
    vec_t       pending_q, pending_d;
    vec_t       rdata_q, rdata_d;
    logic       cpu_q, cpu_d;
    logic [7:0] id_q, id_d;

    vec_t       sync;
    vec_t       line_set;
    vec_t       soft_set;
    vec_t       w1c;
    vec_t       masked;
    vec_t       lowest;
    vec_t       grant;
    logic       dispatch;
    logic [7:0] grant_id;

    // Synchroniser chain; the last stage is the sampled line value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.interrupts;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        line_set = (mode_q & sync & ~sync_prev_q) | (~mode_q & sync);
        soft_set = (bus.cfg_we && bus.cfg_addr == AddrSoftTrig) ? bus.cfg_wdata : '0;
        w1c      = (bus.cfg_we && bus.cfg_addr == AddrPending) ? bus.cfg_wdata : '0;

        masked   = pending_q & enable_q;
        // Two's-complement trick isolates the lowest set bit.
        lowest   = masked & (-masked);
        dispatch = !bus.intDisabled && !cpu_q && (|masked);
        grant    = dispatch ? lowest : '0;
    end

    // OR-encoder: lowest is one-hot (or zero), so OR-ing index+1 yields the ID.
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < int'(NUM_INTERRUPTS); i++) begin
            if (lowest[i]) begin
                grant_id = grant_id | 8'(i + 1);
            end
        end
    end

    always_comb begin
        // Set beats clear so a coincident event is never lost.
        pending_d = (pending_q & ~(w1c | grant)) | line_set | soft_set;

        enable_d = enable_q;
        mode_d   = mode_q;
        if (bus.cfg_we && bus.cfg_addr == AddrEnable) begin
            enable_d = bus.cfg_wdata;
        end
        if (bus.cfg_we && bus.cfg_addr == AddrMode) begin
            mode_d = bus.cfg_wdata;
        end

        // Acknowledge overrides dispatch.
        cpu_d = cpu_q;
        id_d  = id_q;
        if (bus.intDisabled) begin
            cpu_d = 1'b0;
        end else if (dispatch) begin
            cpu_d = 1'b1;
            id_d  = grant_id;
        end

        rdata_d = '0;
        unique case (bus.cfg_addr)
            AddrEnable:   rdata_d = enable_q;
            AddrMode:     rdata_d = mode_q;
            AddrPending:  rdata_d = pending_q;
            AddrSoftTrig: rdata_d = '0;
            default:      rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_prev_q <= '0;
            enable_q    <= '1;
            mode_q      <= '1;
            pending_q   <= '0;
            rdata_q     <= '0;
            cpu_q       <= 1'b0;
            id_q        <= '0;
        end else begin
            sync_prev_q <= sync;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            rdata_q     <= rdata_d;
            cpu_q       <= cpu_d;
            id_q        <= id_d;
        end
    end

    assign bus.cfg_rdata = rdata_q;
    assign bus.intCPU    = cpu_q;
    assign bus.intID     = id_q;

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Self-checking bench for vectored_interrupt_controller: directed table, hand sequences for
// multi-cycle corners, and randomized stimulus against a behavioural model.
module tb_vectored_interrupt_controller;

    localparam int N = 16;
    localparam int S = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vectored_interrupt_controller_if #(.NUM_INTERRUPTS(N)) bus ();

    vectored_interrupt_controller #(
        .NUM_INTERRUPTS (N),
        .SYNC_STAGES    (S)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [N-1:0] m_hist[$];   // sampled line values, newest first
    bit [N-1:0] m_enable, m_mode, m_pend, m_rdata;
    bit         m_cpu;
    bit [7:0]   m_id;

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i <= S; i++) m_hist.push_back('0);
        m_enable = '1;
        m_mode   = '1;
        m_pend   = '0;
        m_rdata  = '0;
        m_cpu    = 1'b0;
        m_id     = '0;
    endfunction

    function automatic void model_update(input bit rst, input bit [N-1:0] irq, input bit dis,
                                         input bit we, input bit [1:0] addr,
                                         input bit [N-1:0] wd);
        bit [N-1:0] cur, prv, np;
        bit found;
        int k;
        if (rst) begin
            model_reset();
            return;
        end
        cur = m_hist[S-1];
        prv = m_hist[S];
        case (addr)
            2'd0: m_rdata = m_enable;
            2'd1: m_rdata = m_mode;
            2'd2: m_rdata = m_pend;
            default: m_rdata = '0;
        endcase
        found = 1'b0;
        k = 0;
        if (!dis && !m_cpu) begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i] && m_enable[i]) begin
                    k = i;
                    found = 1'b1;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            bit keep, set;
            keep = m_pend[i] && !(we && addr == 2'd2 && wd[i]) && !(found && i == k);
            set  = (m_mode[i] ? (cur[i] && !prv[i]) : cur[i]) || (we && addr == 2'd3 && wd[i]);
            np[i] = keep || set;
        end
        m_pend = np;
        if (dis) m_cpu = 1'b0;
        else if (found) begin
            m_cpu = 1'b1;
            m_id  = 8'(k + 1);
        end
        if (we && addr == 2'd0) m_enable = wd;
        if (we && addr == 2'd1) m_mode = wd;
        m_hist.push_front(irq);
        void'(m_hist.pop_back());
    endfunction

    // One clock: advance, update model from the inputs that were sampled, compare.
    task automatic cycle();
        @(posedge clk);
        #1;
        model_update(reset, bus.interrupts, bus.intDisabled, bus.cfg_we, bus.cfg_addr,
                     bus.cfg_wdata);
        chk("model_intCPU", 32'(bus.intCPU), 32'(m_cpu));
        chk("model_intID", 32'(bus.intID), 32'(m_id));
        chk("model_rdata", 32'(bus.cfg_rdata), 32'(m_rdata));
    endtask

    task automatic drive(input logic we, input logic [1:0] addr, input logic [N-1:0] wd);
        bus.cfg_we    = we;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wd;
    endtask

    typedef struct {
        logic [N-1:0] irq;
        logic         dis;
        logic         we;
        logic [1:0]   addr;
        logic [N-1:0] wdata;
        logic         exp_cpu;
        logic [7:0]   exp_id;
        logic         chk_rd;
        logic [N-1:0] exp_rd;
    } vec_t;

    vec_t tbl[21];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit seen;

        // irq, dis, we, addr, wdata, exp_cpu, exp_id, chk_rd, exp_rd
        tbl[0]  = '{16'h0012, 0, 0, 2'd0, 16'h0000, 0, 8'd0,  1, 16'hFFFF};
        tbl[1]  = '{16'h0000, 0, 0, 2'd0, 16'h0000, 0, 8'd0,  0, 16'h0000};
        tbl[2]  = '{16'h0000, 0, 0, 2'd0, 16'h0000, 0, 8'd0,  0, 16'h0000};
        tbl[3]  = '{16'h0000, 0, 0, 2'd0, 16'h0000, 1, 8'd2,  0, 16'h0000};
        tbl[4]  = '{16'h0000, 1, 0, 2'd0, 16'h0000, 0, 8'd2,  0, 16'h0000};
        tbl[5]  = '{16'h0000, 0, 0, 2'd0, 16'h0000, 1, 8'd5,  0, 16'h0000};
        tbl[6]  = '{16'h0000, 1, 0, 2'd0, 16'h0000, 0, 8'd5,  0, 16'h0000};
        tbl[7]  = '{16'h0000, 0, 0, 2'd2, 16'h0000, 0, 8'd5,  1, 16'h0000};
        tbl[8]  = '{16'h0000, 0, 1, 2'd3, 16'h0400, 0, 8'd5,  1, 16'h0000};
        tbl[9]  = '{16'h0000, 0, 0, 2'd3, 16'h0000, 1, 8'd11, 1, 16'h0000};
        tbl[10] = '{16'h0000, 1, 0, 2'd3, 16'h0000, 0, 8'd11, 0, 16'h0000};
        tbl[11] = '{16'h0000, 0, 0, 2'd2, 16'h0000, 0, 8'd11, 1, 16'h0000};
        tbl[12] = '{16'h0000, 0, 1, 2'd0, 16'hFFFE, 0, 8'd11, 1, 16'hFFFF};
        tbl[13] = '{16'h0001, 0, 0, 2'd0, 16'h0000, 0, 8'd11, 1, 16'hFFFE};
        tbl[14] = '{16'h0000, 0, 0, 2'd0, 16'h0000, 0, 8'd11, 0, 16'h0000};
        tbl[15] = '{16'h0000, 0, 0, 2'd0, 16'h0000, 0, 8'd11, 0, 16'h0000};
        tbl[16] = '{16'h0000, 0, 0, 2'd2, 16'h0000, 0, 8'd11, 1, 16'h0001};
        tbl[17] = '{16'h0000, 0, 1, 2'd0, 16'hFFFF, 0, 8'd11, 1, 16'hFFFE};
        tbl[18] = '{16'h0000, 0, 0, 2'd0, 16'h0000, 1, 8'd1,  1, 16'hFFFF};
        tbl[19] = '{16'h0000, 1, 0, 2'd0, 16'h0000, 0, 8'd1,  0, 16'h0000};
        tbl[20] = '{16'h0000, 0, 0, 2'd0, 16'h0000, 0, 8'd1,  0, 16'h0000};

        model_reset();
        reset = 1'b1;
        bus.interrupts  = '0;
        bus.intDisabled = 1'b0;
        drive(1'b0, 2'd0, '0);
        repeat (3) cycle();
        chk("reset_intCPU", 32'(bus.intCPU), 32'd0);
        chk("reset_intID", 32'(bus.intID), 32'd0);
        chk("reset_rdata", 32'(bus.cfg_rdata), 32'd0);
        reset = 1'b0;

        // Directed table
        for (int r = 0; r < 21; r++) begin
            bus.interrupts  = tbl[r].irq;
            bus.intDisabled = tbl[r].dis;
            drive(tbl[r].we, tbl[r].addr, tbl[r].wdata);
            cycle();
            chk($sformatf("tbl%0d_intCPU", r), 32'(bus.intCPU), 32'(tbl[r].exp_cpu));
            chk($sformatf("tbl%0d_intID", r), 32'(bus.intID), 32'(tbl[r].exp_id));
            if (tbl[r].chk_rd)
                chk($sformatf("tbl%0d_rdata", r), 32'(bus.cfg_rdata), 32'(tbl[r].exp_rd));
        end
        drive(1'b0, 2'd0, '0);

        // Edge on bit7 coinciding with a W1C of bit7: set wins
        bus.intDisabled = 1'b1;
        drive(1'b1, 2'd3, 16'h0080);
        cycle();
        drive(1'b0, 2'd0, '0);
        bus.interrupts = 16'h0080;
        cycle();
        bus.interrupts = 16'h0000;
        cycle();
        drive(1'b1, 2'd2, 16'h0080);
        cycle();
        drive(1'b0, 2'd2, '0);
        cycle();
        chk("collide_pending7", 32'(bus.cfg_rdata), 32'h0080);
        bus.intDisabled = 1'b0;
        cycle();
        chk("collide_intCPU", 32'(bus.intCPU), 32'd1);
        chk("collide_intID", 32'(bus.intID), 32'd8);
        bus.intDisabled = 1'b1;
        cycle();
        bus.intDisabled = 1'b0;
        cycle();

        // Level mode on line 4 re-dispatches after each acknowledge
        drive(1'b1, 2'd1, 16'hFFF7);
        cycle();
        drive(1'b0, 2'd0, '0);
        bus.interrupts = 16'h0008;
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            cycle();
            if (bus.intCPU === 1'b1) got = 1'b1;
        end
        chk("level_first_req", 32'(got), 32'd1);
        chk("level_first_id", 32'(bus.intID), 32'd4);
        bus.intDisabled = 1'b1;
        repeat (2) cycle();
        bus.intDisabled = 1'b0;
        cycle();
        chk("level_redispatch", 32'(bus.intCPU), 32'd1);
        chk("level_redispatch_id", 32'(bus.intID), 32'd4);
        bus.intDisabled = 1'b1;
        cycle();
        bus.interrupts = 16'h0000;
        repeat (4) cycle();
        drive(1'b1, 2'd2, 16'h0008);
        cycle();
        drive(1'b0, 2'd0, '0);
        bus.intDisabled = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 6; t++) begin
            cycle();
            if (bus.intCPU !== 1'b0) seen = 1'b1;
        end
        chk("level_no_req_after_drop", 32'(seen), 32'd0);
        drive(1'b1, 2'd1, 16'hFFFF);
        cycle();
        drive(1'b0, 2'd0, '0);
        cycle();

        // Reset mid-request with PENDING=0x00F0
        drive(1'b1, 2'd3, 16'h00F8);
        cycle();
        drive(1'b0, 2'd0, '0);
        cycle();
        drive(1'b1, 2'd0, 16'h1234);
        cycle();
        drive(1'b1, 2'd1, 16'h0F0F);
        cycle();
        drive(1'b0, 2'd2, '0);
        cycle();
        chk("pre_reset_intCPU", 32'(bus.intCPU), 32'd1);
        chk("pre_reset_pending", 32'(bus.cfg_rdata), 32'h00F0);
        reset = 1'b1;
        bus.interrupts = 16'h0002;   // held through reset release
        cycle();
        chk("midreset_intCPU", 32'(bus.intCPU), 32'd0);
        chk("midreset_intID", 32'(bus.intID), 32'd0);
        chk("midreset_rdata", 32'(bus.cfg_rdata), 32'd0);
        reset = 1'b0;
        drive(1'b0, 2'd0, '0);
        cycle();
        chk("post_reset_enable", 32'(bus.cfg_rdata), 32'hFFFF);
        drive(1'b0, 2'd1, '0);
        cycle();
        chk("post_reset_mode", 32'(bus.cfg_rdata), 32'hFFFF);
        drive(1'b0, 2'd2, '0);
        cycle();
        chk("post_reset_pending", 32'(bus.cfg_rdata), 32'h0000);
        cycle();
        chk("held_through_reset_req", 32'(bus.intCPU), 32'd1);
        chk("held_through_reset_id", 32'(bus.intID), 32'd2);
        bus.interrupts = '0;
        bus.intDisabled = 1'b1;
        cycle();
        bus.intDisabled = 1'b0;
        cycle();

        // Randomized stimulus against the model
        for (int c = 0; c < 1500; c++) begin
            bus.interrupts = bus.interrupts ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(3) == 0) bus.intDisabled = ~bus.intDisabled;
            if ($urandom_range(5) == 0)
                drive(1'b1, 2'($urandom_range(3)), N'($urandom));
            else
                drive(1'b0, 2'($urandom_range(3)), '0);
            reset = ($urandom_range(199) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
